dai_rx: RTL and testbench

- Serial receiver that sits directly downstream of the DAI transmitter and consumes its bclk, lrclk and serial data.
- Deserializes the MSB-first 16-bit words into parallel left and right samples and flags framing errors.
- Used as a loopback checker and as the capture front-end for the audio path.
- All logic runs on clk_2048; bclk and lrclk are treated as data signals sampled in that domain, with no clocking on bclk.

---
 rtl/dai_rx_if.sv | 25 ++
 rtl/dai_rx.sv | 171 +++++++++++++++++
 tb/tb_dai_rx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dai_rx_if.sv
// Signal bundle between the DAI serial link/control side and the dai_rx receiver.
// The master side drives the serial lines and err_clear; the slave side returns samples and status.
interface dai_rx_if #(
  parameter int WIDTH = 16
);
  logic             bclk;
  logic             lrclk;
  logic             sdata;
  logic             err_clear;
  logic [WIDTH-1:0] left_sample;
  logic [WIDTH-1:0] right_sample;
  logic             sample_valid;
  logic             locked;
  logic             frame_error;

  modport master (
    output bclk, lrclk, sdata, err_clear,
    input  left_sample, right_sample, sample_valid, locked, frame_error
  );

  modport slave (
    input  bclk, lrclk, sdata, err_clear,
    output left_sample, right_sample, sample_valid, locked, frame_error
  );
endinterface

// File: rtl/dai_rx.sv
// DAI serial receiver: oversamples bclk/lrclk/sdata on clk_2048, deserializes MSB-first
// words into left/right samples, tracks word framing and flags short/long words.
module dai_rx #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic    clk_2048,
  input  logic    reset,
  dai_rx_if.slave dai
);
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(WIDTH + 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);

  typedef enum logic {UNLOCKED, RECEIVING} state_t;
  state_t state_q, state_d;

  logic             bclk_r, bclk_rr, lrclk_r, sdata_r;
  logic             bit_evt, boundary, word_ok, to_hit;
  logic             lr_prev, lr_seen;
  logic [WIDTH-1:0] shifter;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;
  logic [TO_W-1:0]  to_cnt;
  logic             store_l, store_r, word_err;

  logic [WIDTH-1:0] word_p1, word_p2;
  logic             store_l_p1, store_r_p1, err_p1;
  logic             store_l_p2, store_r_p2, err_p2;
  logic [WIDTH-1:0] left_q, right_q;
  logic             vld_p3, have_left, frame_err_q;

  assign bit_evt  = bclk_r & ~bclk_rr;
  // lr_seen stops the first bit after reset from looking like a boundary against lr_prev's reset value
  assign boundary = bit_evt & lr_seen & (lrclk_r != lr_prev);
  assign word_ok  = (bit_cnt == CNT_FULL) & ~overrun;
  assign to_hit   = (to_cnt == TO_MAX);

  always_comb begin
    state_d  = state_q;
    store_l  = 1'b0;
    store_r  = 1'b0;
    word_err = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (boundary) state_d = RECEIVING;
      end
      RECEIVING: begin
        if (boundary) begin
          if (word_ok) begin
            store_l = lr_prev;
            store_r = ~lr_prev;
          end else begin
            word_err = 1'b1;
          end
        end else if (!bit_evt && to_hit) begin
          state_d = UNLOCKED;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // p0: input sampling and bclk edge history
  always_ff @(posedge clk_2048 or posedge reset) begin
    if (reset) begin
      bclk_r  <= 1'b0;
      bclk_rr <= 1'b0;
      lrclk_r <= 1'b0;
      sdata_r <= 1'b0;
    end else begin
      bclk_r  <= dai.bclk;
      bclk_rr <= bclk_r;
      lrclk_r <= dai.lrclk;
      sdata_r <= dai.sdata;
    end
  end

  // p1: framing state, shifter and word-complete strobes
  always_ff @(posedge clk_2048 or posedge reset) begin
    if (reset) begin
      state_q    <= UNLOCKED;
      lr_prev    <= 1'b0;
      lr_seen    <= 1'b0;
      shifter    <= '0;
      bit_cnt    <= '0;
      overrun    <= 1'b0;
      to_cnt     <= '0;
      word_p1    <= '0;
      store_l_p1 <= 1'b0;
      store_r_p1 <= 1'b0;
      err_p1     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bit_evt) begin
        lr_prev <= lrclk_r;
        lr_seen <= 1'b1;
        to_cnt  <= '0;
      end else if (!to_hit) begin
        to_cnt  <= to_cnt + TO_W'(1);
      end
      if (boundary) begin
        shifter <= {{(WIDTH-1){1'b0}}, sdata_r};
        bit_cnt <= CNT_W'(1);
        overrun <= 1'b0;
      end else if (bit_evt) begin
        if (state_q == UNLOCKED) begin
          shifter <= {shifter[WIDTH-2:0], sdata_r};
        end else if (bit_cnt < CNT_FULL) begin
          shifter <= {shifter[WIDTH-2:0], sdata_r};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end else begin
          overrun <= 1'b1;
          bit_cnt <= CNT_OVER;
        end
      end
      word_p1    <= shifter;
      store_l_p1 <= store_l;
      store_r_p1 <= store_r;
      err_p1     <= word_err;
    end
  end

  // p2: alignment stage
  always_ff @(posedge clk_2048 or posedge reset) begin
    if (reset) begin
      word_p2    <= '0;
      store_l_p2 <= 1'b0;
      store_r_p2 <= 1'b0;
      err_p2     <= 1'b0;
    end else begin
      word_p2    <= word_p1;
      store_l_p2 <= store_l_p1;
      store_r_p2 <= store_r_p1;
      err_p2     <= err_p1;
    end
  end

  // p3: sample registers, pairing, sticky error
  always_ff @(posedge clk_2048 or posedge reset) begin
    if (reset) begin
      left_q      <= '0;
      right_q     <= '0;
      vld_p3      <= 1'b0;
      have_left   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (store_l_p2) left_q  <= word_p2;
      if (store_r_p2) right_q <= word_p2;
      vld_p3 <= store_r_p2 & have_left;
      if (err_p2 || state_q == UNLOCKED || (store_r_p2 && have_left)) begin
        have_left <= 1'b0;
      end else if (store_l_p2) begin
        have_left <= 1'b1;
      end
      if (err_p2) begin
        frame_err_q <= 1'b1;
      end else if (dai.err_clear) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  assign dai.left_sample  = left_q;
  assign dai.right_sample = right_q;
  assign dai.sample_valid = vld_p3;
  assign dai.locked       = (state_q == RECEIVING);
  assign dai.frame_error  = frame_err_q;
endmodule

// File: tb/tb_dai_rx.sv
// Bench for dai_rx: a word-level transmitter model feeds a scoreboard of expected stereo
// pairs; a table of frames plus hand-written timeout and reset sequences drive the link.
module tb_dai_rx;
  localparam int WIDTH = 16;

  logic clk_2048 = 1'b0;
  logic reset    = 1'b1;
  always #5 clk_2048 = ~clk_2048;

  dai_rx_if #(.WIDTH(WIDTH)) dai ();
  dai_rx #(.WIDTH(WIDTH), .TIMEOUT(64)) dut (
    .clk_2048(clk_2048),
    .reset   (reset),
    .dai     (dai)
  );

  int passed = 0;
  int total  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
  endfunction

  logic [31:0] sb_q[$];
  logic [31:0] exp_pair;
  int  cyc     = 0;
  int  bnd_cyc = 0;
  int  last_v  = -1;
  bit  nom_on  = 1'b0;

  always @(posedge clk_2048) cyc <= cyc + 1;

  always @(negedge clk_2048) begin
    if (!nom_on) last_v = -1;
    if (!reset && dai.sample_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL spurious_valid: sample_valid high with L=%0h R=%0h, no pair expected",
                 dai.left_sample, dai.right_sample);
      end else begin
        exp_pair = sb_q.pop_front();
        check("valid_left", dai.left_sample, exp_pair[31:16]);
        check("valid_right", dai.right_sample, exp_pair[15:0]);
        check("valid_latency", cyc - bnd_cyc, 4);
        if (nom_on && last_v >= 0) check("valid_period", cyc - last_v, 256);
        last_v = cyc;
      end
    end
  end

  // Word-level model of the receiver's framing
  bit          m_seen, m_locked, m_have_left, m_err, m_plr;
  int          m_plen;
  logic [15:0] m_pval, m_left, m_right;

  task automatic model_reset();
    m_seen = 0; m_locked = 0; m_have_left = 0; m_err = 0; m_plr = 0;
    m_plen = 0; m_pval = '0; m_left = '0; m_right = '0;
  endtask

  task automatic word_start(input logic lr);
    if (m_seen && lr != m_plr) begin
      if (m_locked) begin
        if (m_plen == WIDTH) begin
          if (m_plr) begin
            m_left = m_pval;
            m_have_left = 1;
          end else begin
            m_right = m_pval;
            if (m_have_left) begin
              sb_q.push_back({m_left, m_right});
              m_have_left = 0;
            end
          end
        end else begin
          m_err = 1;
          m_have_left = 0;
        end
      end
      m_locked = 1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_left"},   dai.left_sample, 0);
    check({tag, "_right"},  dai.right_sample, 0);
    check({tag, "_valid"},  dai.sample_valid, 0);
    check({tag, "_locked"}, dai.locked, 0);
    check({tag, "_err"},    dai.frame_error, 0);
  endtask

  task automatic send_bit(input logic lr, input logic b, input bit first, input bit clr);
    dai.lrclk = lr;
    dai.sdata = b;
    dai.bclk  = 1'b0;
    repeat (4) @(negedge clk_2048);
    dai.bclk = 1'b1;
    if (first) bnd_cyc = cyc;
    repeat (3) @(negedge clk_2048);
    if (clr) dai.err_clear = 1'b1;
    @(negedge clk_2048);
    dai.err_clear = 1'b0;
  endtask

  task automatic do_pause();
    repeat (40) @(negedge clk_2048);
    check("lock_hold", dai.locked, 1);
    repeat (30) @(negedge clk_2048);
    check("lock_drop", dai.locked, 0);
    check("pause_err", dai.frame_error, m_err);
    m_locked = 0;
    m_have_left = 0;
  endtask

  task automatic do_reset_mid(input logic lr);
    reset = 1'b1;
    model_reset();
    m_seen = 1;
    m_plr  = lr;
    repeat (2) @(negedge clk_2048);
    check_reset_state("midrst");
    reset = 1'b0;
    @(negedge clk_2048);
  endtask

  task automatic send_word(input logic lr, input logic [31:0] val, input int n,
                           input int pause_at, input int rst_at, input bit clr_bnd);
    word_start(lr);
    m_seen = 1;
    m_plr  = lr;
    m_plen = n;
    m_pval = val[15:0];
    for (int i = n - 1; i >= 0; i--) begin
      automatic int k = n - 1 - i;
      if (k == pause_at) do_pause();
      if (k == rst_at) do_reset_mid(lr);
      send_bit(lr, val[i], k == 0, clr_bnd && k == 0);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk_2048);
    dai.err_clear = 1'b1;
    @(negedge clk_2048);
    dai.err_clear = 1'b0;
    m_err = 0;
  endtask

  typedef struct {
    logic [31:0] lv;
    logic [31:0] rv;
    int          ln;
    int          rn;
    bit          clr_before;
    bit          clr_bnd;
    bit          nom;
    logic        exp_err;
    logic        exp_lock;
  } vec_t;

  vec_t tbl [14];

  initial begin
    automatic int r;
    tbl[0]  = '{32'hA5C3, 32'h3C5A, 16, 16, 0, 0, 1, 1'b0, 1'b1};
    tbl[1]  = '{32'hA5C3, 32'h3C5A, 16, 16, 0, 0, 1, 1'b0, 1'b1};
    tbl[2]  = '{32'h0000, 32'hFFFF, 16, 16, 0, 0, 1, 1'b0, 1'b1};
    tbl[3]  = '{32'h8001, 32'h7FFE, 16, 16, 0, 0, 1, 1'b0, 1'b1};
    tbl[4]  = '{32'h1234, 32'hFEDC, 16, 16, 0, 0, 1, 1'b0, 1'b1};
    tbl[5]  = '{32'hA5C3, 32'h3C5A, 16, 16, 0, 0, 1, 1'b0, 1'b1};
    tbl[6]  = '{32'h7FFF, 32'h3C5A, 15, 16, 0, 0, 0, 1'b1, 1'b1};
    tbl[7]  = '{32'hA5C3, 32'h3C5A, 16, 16, 0, 0, 0, 1'b1, 1'b1};
    tbl[8]  = '{32'hA5C3, 32'h3C5A, 16, 16, 1, 0, 0, 1'b0, 1'b1};
    tbl[9]  = '{32'hC0DE, 32'h3FFFE, 16, 18, 0, 0, 0, 1'b0, 1'b1};
    tbl[10] = '{32'h1111, 32'h2222, 16, 16, 0, 0, 0, 1'b1, 1'b1};
    tbl[11] = '{32'h4444, 32'h5555, 16, 16, 1, 0, 0, 1'b0, 1'b1};
    tbl[12] = '{32'h1234, 32'h3C5A, 15, 16, 0, 1, 0, 1'b1, 1'b1};
    tbl[13] = '{32'h9876, 32'h6789, 16, 16, 1, 0, 0, 1'b0, 1'b1};

    dai.bclk = 1'b0;
    dai.lrclk = 1'b0;
    dai.sdata = 1'b0;
    dai.err_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_2048);
    check_reset_state("rst");
    reset = 1'b0;
    @(negedge clk_2048);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].clr_before) pulse_clear();
      nom_on = tbl[i].nom;
      send_word(1'b1, tbl[i].lv, tbl[i].ln, -1, -1, 1'b0);
      send_word(1'b0, tbl[i].rv, tbl[i].rn, -1, -1, tbl[i].clr_bnd);
      check($sformatf("err_%0d", i), dai.frame_error, tbl[i].exp_err);
      check($sformatf("lock_%0d", i), dai.locked, tbl[i].exp_lock);
      check($sformatf("left_%0d", i), dai.left_sample, m_left);
      check($sformatf("right_%0d", i), dai.right_sample, m_right);
    end
    nom_on = 1'b0;

    // bclk stalls mid-word for 70 cycles, then the link resumes
    send_word(1'b1, 32'h5A5A, 16, 8, -1, 1'b0);
    send_word(1'b0, 32'h0F0F, 16, -1, -1, 1'b0);
    send_word(1'b1, 32'hF00D, 16, -1, -1, 1'b0);
    send_word(1'b0, 32'hCAFE, 16, -1, -1, 1'b0);
    send_word(1'b1, 32'h1357, 16, -1, -1, 1'b0);
    check("relock", dai.locked, 1);
    check("relock_err", dai.frame_error, 0);
    check("relock_left", dai.left_sample, m_left);
    check("relock_right", dai.right_sample, m_right);
    send_word(1'b0, 32'h2468, 16, -1, -1, 1'b0);

    // asynchronous reset at a random bit of a frame
    r = $urandom_range(1, 31);
    send_word(1'b1, 32'hA5C3, 16, -1, (r < 16) ? r : -1, 1'b0);
    send_word(1'b0, 32'h3C5A, 16, -1, (r >= 16) ? r - 16 : -1, 1'b0);
    for (int j = 0; j < 2; j++) begin
      send_word(1'b1, 32'hA5C3, 16, -1, -1, 1'b0);
      send_word(1'b0, 32'h3C5A, 16, -1, -1, 1'b0);
    end
    send_word(1'b1, 32'h0000, 16, -1, -1, 1'b0);
    repeat (20) @(negedge clk_2048);
    check("post_rst_err", dai.frame_error, 0);
    check("post_rst_lock", dai.locked, 1);
    check("post_rst_left", dai.left_sample, 16'hA5C3);
    check("post_rst_right", dai.right_sample, 16'h3C5A);
    check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end
endmodule
